// File: rtl/mips32_pipe.sv
// mips32_pipe: 5-stage in-order MIPS32-subset core (IF, ID, EX, MEM, WB).
// One unified word-addressed memory holds both code and data. The core
// forwards EX operands from EX/MEM and MEM/WB, stalls one cycle on a
// load-use hazard, and flushes the two younger stages on a taken branch.
//
// Ports:
//   clk1   - system clock, all state updates on its rising edge
//   rst_n  - asynchronous active-low reset (pipeline only; regfile/mem kept)
//   halted - high once a HLT has retired; held until reset
module mips32_pipe #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic clk1,
  input  logic rst_n,
  output logic halted
);
  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [5:0] OP_ADD = 6'd0,  OP_SUB = 6'd1,  OP_AND = 6'd2,  OP_OR = 6'd3;
  localparam logic [5:0] OP_SLT = 6'd4,  OP_MUL = 6'd5,  OP_LW = 6'd8,   OP_SW = 6'd9;
  localparam logic [5:0] OP_ADDI = 6'd10, OP_SUBI = 6'd11, OP_SLTI = 6'd12;
  localparam logic [5:0] OP_BNEQZ = 6'd13, OP_BEQZ = 6'd14, OP_HLT = 6'd63;

  logic [31:0] mem [0:MEM_WORDS-1];
  logic [31:0] regfile [0:31];
  logic [31:0] pc;
  logic        taken_branch;

  // Pipeline registers. A bubble is simply valid/write-enable bits cleared.
  logic        ifid_valid;
  logic [31:0] ifid_ir, ifid_pc;

  logic        idex_valid, idex_wen;
  logic [5:0]  idex_op;
  logic [4:0]  idex_rs, idex_rt, idex_dest;
  logic [31:0] idex_a, idex_b, idex_imm, idex_pc;

  logic        exmem_wen, exmem_lw, exmem_sw, exmem_hlt;
  logic [4:0]  exmem_dest;
  logic [31:0] exmem_alu, exmem_b;

  logic        memwb_wen, memwb_hlt;
  logic [4:0]  memwb_dest;
  logic [31:0] memwb_res;

  // Once halted nothing retires, so the WB write port is gated here.
  logic wb_we;
  assign wb_we = memwb_wen & ~halted;

  // ---------------- ID: decode and register read ----------------
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic [31:0] id_imm, id_a, id_b;
  logic        id_rr, id_lw, id_sw, id_immop, id_br, id_uses_rs, id_uses_rt, id_wen;

  always_comb begin
    id_op      = ifid_ir[31:26];
    id_rs      = ifid_ir[25:21];
    id_rt      = ifid_ir[20:16];
    id_imm     = {{16{ifid_ir[15]}}, ifid_ir[15:0]};
    id_rr      = (id_op <= OP_MUL);
    id_lw      = (id_op == OP_LW);
    id_sw      = (id_op == OP_SW);
    id_immop   = (id_op == OP_ADDI) | (id_op == OP_SUBI) | (id_op == OP_SLTI);
    id_br      = (id_op == OP_BNEQZ) | (id_op == OP_BEQZ);
    id_uses_rs = id_rr | id_lw | id_sw | id_immop | id_br;
    id_uses_rt = id_rr | id_sw;
    id_dest    = id_rr ? ifid_ir[15:11] : id_rt;
    id_wen     = ifid_valid & (id_rr | id_lw | id_immop) & (id_dest != 5'd0);
    // Write-through: a WB write in this same cycle is visible to the read.
    id_a = regfile[id_rs];
    if (wb_we && memwb_dest == id_rs) id_a = memwb_res;
    if (id_rs == 5'd0) id_a = 32'd0;
    id_b = regfile[id_rt];
    if (wb_we && memwb_dest == id_rt) id_b = memwb_res;
    if (id_rt == 5'd0) id_b = 32'd0;
  end

  // ---------------- EX: forwarding, ALU, branch ----------------
  logic [31:0] ex_a, ex_b, ex_alu, ex_target;
  logic        ex_taken, load_use, hlt_block;

  always_comb begin
    // EX/MEM is checked first so the youngest producer wins.
    ex_a = idex_a;
    if (exmem_wen && exmem_dest == idex_rs)      ex_a = exmem_alu;
    else if (memwb_wen && memwb_dest == idex_rs) ex_a = memwb_res;
    ex_b = idex_b;
    if (exmem_wen && exmem_dest == idex_rt)      ex_b = exmem_alu;
    else if (memwb_wen && memwb_dest == idex_rt) ex_b = memwb_res;

    case (idex_op)
      OP_ADD:               ex_alu = ex_a + ex_b;
      OP_SUB:               ex_alu = ex_a - ex_b;
      OP_AND:               ex_alu = ex_a & ex_b;
      OP_OR:                ex_alu = ex_a | ex_b;
      OP_SLT:               ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
      OP_MUL:               ex_alu = ex_a * ex_b;
      OP_LW, OP_SW, OP_ADDI: ex_alu = ex_a + idex_imm;
      OP_SUBI:              ex_alu = ex_a - idex_imm;
      OP_SLTI:              ex_alu = {31'd0, $signed(ex_a) < $signed(idex_imm)};
      default:              ex_alu = 32'd0;
    endcase

    ex_target = idex_pc + 32'd1 + idex_imm;
    ex_taken  = idex_valid & (((idex_op == OP_BNEQZ) & (ex_a != 32'd0)) |
                              ((idex_op == OP_BEQZ)  & (ex_a == 32'd0)));
    load_use  = ifid_valid & idex_valid & idex_wen & (idex_op == OP_LW) &
                ((id_uses_rs & (id_rs == idex_dest)) | (id_uses_rt & (id_rt == idex_dest)));
    // Once a HLT is past ID, nothing younger may enter EX; this also freezes pc.
    hlt_block = halted | memwb_hlt | exmem_hlt | (idex_valid & (idex_op == OP_HLT));
  end

  // ---------------- Front end: pc, IF/ID, ID/EX ----------------
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;  taken_branch <= 1'b0;
      ifid_valid <= 1'b0; ifid_ir <= 32'd0; ifid_pc <= 32'd0;
      idex_valid <= 1'b0; idex_wen <= 1'b0; idex_op <= 6'd0;
      idex_rs <= 5'd0; idex_rt <= 5'd0; idex_dest <= 5'd0;
      idex_a <= 32'd0; idex_b <= 32'd0; idex_imm <= 32'd0; idex_pc <= 32'd0;
    end else begin
      taken_branch <= ex_taken;
      // Flush takes priority over the load-use stall.
      if (!hlt_block) begin
        if (ex_taken) begin
          pc <= ex_target;
          ifid_valid <= 1'b0;
        end else if (!load_use) begin
          pc <= pc + 32'd1;
          ifid_valid <= 1'b1;
          ifid_ir <= mem[pc[AW-1:0]];
          ifid_pc <= pc;
        end
      end
      if (ex_taken || load_use || hlt_block) begin
        idex_valid <= 1'b0;
        idex_wen   <= 1'b0;
      end else begin
        idex_valid <= ifid_valid;
        idex_wen   <= id_wen;
        idex_op    <= id_op;
        idex_rs    <= id_rs;
        idex_rt    <= id_rt;
        idex_dest  <= id_dest;
        idex_a     <= id_a;
        idex_b     <= id_b;
        idex_imm   <= id_imm;
        idex_pc    <= ifid_pc;
      end
    end
  end

  // ---------------- Back end: EX/MEM, MEM/WB, halt ----------------
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      exmem_wen <= 1'b0; exmem_lw <= 1'b0; exmem_sw <= 1'b0; exmem_hlt <= 1'b0;
      exmem_dest <= 5'd0; exmem_alu <= 32'd0; exmem_b <= 32'd0;
      memwb_wen <= 1'b0; memwb_hlt <= 1'b0; memwb_dest <= 5'd0; memwb_res <= 32'd0;
      halted <= 1'b0;
    end else begin
      exmem_wen  <= idex_wen;
      exmem_lw   <= idex_valid & (idex_op == OP_LW);
      exmem_sw   <= idex_valid & (idex_op == OP_SW);
      exmem_hlt  <= idex_valid & (idex_op == OP_HLT);
      exmem_dest <= idex_dest;
      exmem_alu  <= ex_alu;
      exmem_b    <= ex_b;
      memwb_wen  <= exmem_wen;
      memwb_hlt  <= exmem_hlt;
      memwb_dest <= exmem_dest;
      memwb_res  <= exmem_lw ? mem[exmem_alu[AW-1:0]] : exmem_alu;
      if (memwb_hlt) halted <= 1'b1;
    end
  end

  // Storage is deliberately outside reset so preloaded contents survive.
  always_ff @(posedge clk1) begin
    if (exmem_sw && !halted) mem[exmem_alu[AW-1:0]] <= exmem_b;
  end

  always_ff @(posedge clk1) begin
    if (wb_we) regfile[memwb_dest] <= memwb_res;
  end

endmodule

// File: tb/tb_mips32_pipe.sv
// tb_mips32_pipe: directed programs from the test plan plus randomized
// straight-line programs (with forward branches) checked against an
// instruction-level interpreter kept in this bench.
module tb_mips32_pipe;
  logic clk1 = 1'b0;
  logic rst_n = 1'b1;
  logic halted;

  mips32_pipe #(.MEM_WORDS(1024), .RESET_PC(32'd0)) dut (
    .clk1(clk1), .rst_n(rst_n), .halted(halted)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int failures = 0;
  localparam logic [31:0] NOP_W = 32'h1C00_0000;  // opcode 7: not defined, runs as NOP

  logic [31:0] prog[$];
  logic [31:0] mregs [0:31];
  logic [31:0] mmem  [0:255];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input int op, input int rd, input int rs, input int rt);
    return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rt, input int rs, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task enter_reset();
    @(negedge clk1);
    rst_n = 1'b0;
    @(negedge clk1);
  endtask

  task load_prog();
    for (int i = 0; i < 100; i++) dut.mem[i] <= NOP_W;
    for (int i = 0; i < prog.size(); i++) dut.mem[i] <= prog[i];
    dut.regfile[0] <= 32'd0;
  endtask

  task automatic run_prog(input string name, output int cycles, output int taken);
    @(negedge clk1);
    rst_n = 1'b1;
    cycles = 0;
    taken = 0;
    while (halted !== 1'b1 && cycles < 3000) begin
      @(negedge clk1);
      cycles++;
      if (dut.taken_branch === 1'b1) taken++;
    end
    check({name, "_halted"}, {31'd0, halted}, 32'd1);
    $display("run %s cycles=%0d taken=%0d", name, cycles, taken);
  endtask

  // Sequential ISA interpreter: one instruction at a time, no pipeline notion.
  task model_run();
    logic [31:0] ir, a, b, imm, pcm;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    pcm = 0;
    for (int step = 0; step < 1000; step++) begin
      ir = mmem[pcm[7:0]];
      op = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
      a = mregs[rs]; b = mregs[rt]; imm = {{16{ir[15]}}, ir[15:0]};
      if (op == 6'd63) break;
      pcm = pcm + 1;
      case (op)
        6'd0:  mregs[rd] = a + b;
        6'd1:  mregs[rd] = a - b;
        6'd2:  mregs[rd] = a & b;
        6'd3:  mregs[rd] = a | b;
        6'd4:  mregs[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'd5:  mregs[rd] = a * b;
        6'd8:  mregs[rt] = mmem[8'(a + imm)];
        6'd9:  mmem[8'(a + imm)] = b;
        6'd10: mregs[rt] = a + imm;
        6'd11: mregs[rt] = a - imm;
        6'd12: mregs[rt] = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        6'd13: if (a != 0) pcm = pcm + imm;
        6'd14: if (a == 0) pcm = pcm + imm;
        default: ;
      endcase
      mregs[0] = 32'd0;
    end
  endtask

  task gen_random();
    int n, k, off;
    n = 20;
    prog.delete();
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 12);
      if (k <= 5)
        prog.push_back(r_ins(k, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
      else if (k == 6)
        prog.push_back(i_ins(8, $urandom_range(0, 7), 0, 200 + $urandom_range(0, 15)));
      else if (k == 7)
        prog.push_back(i_ins(9, $urandom_range(0, 7), 0, 200 + $urandom_range(0, 15)));
      else if (k <= 10)
        prog.push_back(i_ins(k + 2, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535)));
      else if (k == 11) begin
        off = $urandom_range(0, 3);
        if (i + 1 + off > n) off = n - i - 1;
        prog.push_back(i_ins($urandom_range(13, 14), 0, $urandom_range(0, 7), off));
      end else
        prog.push_back(32'h5000_0000);  // opcode 20, NOP
    end
    prog.push_back(i_ins(63, 0, 0, 0));
    prog.push_back(i_ins(9, 1, 0, 215));  // wrong-path store after HLT
    prog.push_back(i_ins(10, 1, 0, 99));
  endtask

  int cyc, tk, cyc_a, cyc_b;
  logic [31:0] pc_hold, v;

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset_pc", dut.pc, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    check("reset_taken", {31'd0, dut.taken_branch}, 32'd0);

    // Back-to-back dependencies
    enter_reset();
    prog = '{i_ins(10, 1, 0, 5), r_ins(0, 2, 1, 1), r_ins(1, 3, 2, 1), i_ins(63, 0, 0, 0)};
    load_prog();
    for (int r = 1; r <= 3; r++) dut.regfile[r] <= 32'hDEAD_BEEF;
    run_prog("b2b", cyc, tk);
    check("b2b_r1", dut.regfile[1], 32'd5);
    check("b2b_r2", dut.regfile[2], 32'd10);
    check("b2b_r3", dut.regfile[3], 32'd5);

    // Async reset while halted, between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("areset_pc", dut.pc, 32'd0);
    check("areset_halted", {31'd0, halted}, 32'd0);
    check("areset_keep_r2", dut.regfile[2], 32'd10);
    check("areset_keep_mem0", dut.mem[0], prog[0]);

    // Load-use: one stall cycle compared with an independent variant
    enter_reset();
    prog = '{i_ins(8, 4, 0, 50), r_ins(0, 5, 4, 4), i_ins(63, 0, 0, 0)};
    load_prog();
    dut.mem[50] <= 32'd7;
    dut.regfile[4] <= 32'hDEAD; dut.regfile[5] <= 32'hDEAD; dut.regfile[6] <= 32'd3;
    run_prog("lu_dep", cyc_a, tk);
    check("lu_r4", dut.regfile[4], 32'd7);
    check("lu_r5", dut.regfile[5], 32'd14);
    enter_reset();
    prog = '{i_ins(8, 4, 0, 50), r_ins(0, 5, 6, 6), i_ins(63, 0, 0, 0)};
    load_prog();
    run_prog("lu_indep", cyc_b, tk);
    check("lu_indep_r5", dut.regfile[5], 32'd6);
    check("lu_stall_cycles", 32'(cyc_a - cyc_b), 32'd1);

    // Branch flush
    enter_reset();
    prog = '{i_ins(14, 0, 0, 2), i_ins(10, 8, 0, 1), i_ins(10, 9, 0, 1), i_ins(63, 0, 0, 0)};
    load_prog();
    dut.regfile[8] <= 32'd0; dut.regfile[9] <= 32'd0;
    run_prog("branch", cyc, tk);
    check("br_r8", dut.regfile[8], 32'd0);
    check("br_r9", dut.regfile[9], 32'd0);
    check("br_taken_pulses", 32'(tk), 32'd1);

    // Halt, r0 write, wrong-path instructions after HLT
    enter_reset();
    prog = '{i_ins(10, 0, 0, 9), i_ins(63, 0, 0, 0), i_ins(9, 0, 0, 60), i_ins(10, 10, 0, 7)};
    load_prog();
    dut.mem[60] <= 32'h1234; dut.regfile[10] <= 32'h55;
    run_prog("halt", cyc, tk);
    pc_hold = dut.pc;
    repeat (6) @(negedge clk1);
    check("halt_pc_frozen", dut.pc, pc_hold);
    check("halt_r0", dut.regfile[0], 32'd0);
    check("halt_mem60", dut.mem[60], 32'h1234);
    check("halt_r10", dut.regfile[10], 32'h55);
    check("halt_stays", {31'd0, halted}, 32'd1);

    // Caesar cipher loop (bneqz at word 17 with imm 0xFFF3 -> word 5)
    enter_reset();
    prog = '{i_ins(10, 1, 0, 100), i_ins(10, 3, 0, 3), i_ins(10, 6, 0, 3), i_ins(10, 2, 0, 0), NOP_W,
             r_ins(0, 4, 1, 2), i_ins(8, 5, 4, 0), r_ins(0, 5, 5, 3), i_ins(9, 5, 4, 0),
             i_ins(10, 2, 2, 1), r_ins(4, 7, 2, 6), NOP_W, NOP_W, NOP_W, NOP_W, NOP_W, NOP_W,
             i_ins(13, 0, 7, 16'hFFF3), i_ins(63, 0, 0, 0)};
    load_prog();
    dut.mem[100] <= 32'd65; dut.mem[101] <= 32'd66; dut.mem[102] <= 32'd67;
    run_prog("caesar", cyc, tk);
    check("caesar_m100", dut.mem[100], 32'd68);
    check("caesar_m101", dut.mem[101], 32'd69);
    check("caesar_m102", dut.mem[102], 32'd70);
    check("caesar_r2", dut.regfile[2], 32'd3);
    check("caesar_r7", dut.regfile[7], 32'd0);
    check("caesar_taken", 32'(tk), 32'd2);

    // Reset in the middle of the loop
    enter_reset();
    load_prog();
    @(negedge clk1);
    rst_n = 1'b1;
    repeat (12) @(negedge clk1);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_pc", dut.pc, 32'd0);
    check("midrun_halted", {31'd0, halted}, 32'd0);
    check("midrun_taken", {31'd0, dut.taken_branch}, 32'd0);

    // Random programs against the interpreter
    for (int t = 0; t < 25; t++) begin
      enter_reset();
      gen_random();
      for (int i = 0; i < 256; i++) mmem[i] = 32'd0;
      for (int i = 0; i < 100; i++) mmem[i] = NOP_W;
      for (int i = 0; i < prog.size(); i++) mmem[i] = prog[i];
      load_prog();
      for (int i = 200; i < 216; i++) begin
        v = $urandom;
        mmem[i] = v;
        dut.mem[i] <= v;
      end
      mregs[0] = 32'd0;
      for (int r = 1; r < 32; r++) begin
        v = (r < 8) ? (($urandom_range(0, 3) == 0) ? 32'd0 : $urandom) : 32'd0;
        mregs[r] = v;
        dut.regfile[r] <= v;
      end
      model_run();
      run_prog($sformatf("rand%0d", t), cyc, tk);
      for (int r = 0; r < 8; r++)
        check($sformatf("rand%0d_r%0d", t, r), dut.regfile[r], mregs[r]);
      for (int i = 200; i < 216; i++)
        check($sformatf("rand%0d_m%0d", t, i), dut.mem[i], mmem[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
